// File: rtl/cm0_wakeup_ctrl.sv
// cm0_wakeup_ctrl: Cortex-M0 WIC enable handshake, sensitivity capture and wake detection.
// Define WIC_INPUT_SYNC_EN to pass IRQ/NMI/RXEV through a 2-flop synchronizer before detection.
`timescale 1ns/1ps
module cm0_wakeup_ctrl #(
    parameter int NUMIRQ = 32
) (
    input  logic              SCLK,
    input  logic              HRESET,
    input  logic              WICENREQ,
    output logic              WICENACK,
    output logic              WICDSREQn,
    input  logic              WICDSACKn,
    input  logic              WICLOAD,
    input  logic              WICCLEAR,
    input  logic [NUMIRQ-1:0] WICMASKISR,
    input  logic              WICMASKNMI,
    input  logic              WICMASKRXEV,
    input  logic [NUMIRQ-1:0] IRQ,
    input  logic              NMI,
    input  logic              RXEV,
    output logic [NUMIRQ+1:0] WICSENSE,
    output logic [NUMIRQ+1:0] WICPEND,
    output logic              WAKEUP
);
    localparam int W = NUMIRQ + 2;

    typedef enum logic [1:0] {ST_OFF, ST_REQ, ST_ON} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   sense_q, sense_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           dsreq_n_q, dsreq_n_d;
    logic           enack_q, enack_d;
    logic           wakeup_q, wakeup_d;
    logic [W-1:0]   raw_in, det_in;

    assign raw_in = {IRQ, NMI, RXEV};

`ifdef WIC_INPUT_SYNC_EN
    logic [W-1:0] sync1_q, sync2_q;

    // Synchronizer is deliberately untouched by WICCLEAR; only reset clears it.
    always_ff @(posedge SCLK or posedge HRESET) begin
        if (HRESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end
    assign det_in = sync2_q;
`else
    assign det_in = raw_in;
`endif

    always_comb begin
        state_d = state_q;
        sense_d = sense_q;
        pend_d  = pend_q;
        case (state_q)
            ST_OFF: if (WICENREQ) state_d = ST_REQ;
            ST_REQ: begin
                if (!WICENREQ)       state_d = ST_OFF;
                else if (!WICDSACKn) state_d = ST_ON;
            end
            ST_ON: begin
                if (!WICENREQ || WICDSACKn) begin
                    state_d = ST_OFF;
                    sense_d = '0;
                    pend_d  = '0;
                end else begin
                    // Previous-cycle sensitivity gates detection, so a load never self-triggers.
                    pend_d = pend_q | (sense_q & det_in);
                    if (WICLOAD) sense_d = {WICMASKISR, WICMASKNMI, WICMASKRXEV};
                end
            end
            default: state_d = ST_OFF;
        endcase
        if (WICCLEAR) begin
            sense_d = '0;
            pend_d  = '0;
        end
        dsreq_n_d = (state_d == ST_OFF);
        enack_d   = (state_d == ST_ON);
        wakeup_d  = |pend_d;
    end

    always_ff @(posedge SCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_OFF;
            sense_q   <= '0;
            pend_q    <= '0;
            dsreq_n_q <= 1'b1;
            enack_q   <= 1'b0;
            wakeup_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sense_q   <= sense_d;
            pend_q    <= pend_d;
            dsreq_n_q <= dsreq_n_d;
            enack_q   <= enack_d;
            wakeup_q  <= wakeup_d;
        end
    end

    assign WICSENSE  = sense_q;
    assign WICPEND   = pend_q;
    assign WICDSREQn = dsreq_n_q;
    assign WICENACK  = enack_q;
    assign WAKEUP    = wakeup_q;
endmodule

// File: tb/tb_cm0_wakeup_ctrl.sv
// Bench for cm0_wakeup_ctrl: directed test-plan scenarios then randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_cm0_wakeup_ctrl;
    localparam int NUMIRQ = 32;
    localparam int W = NUMIRQ + 2;
`ifdef WIC_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              SCLK = 1'b0;
    logic              HRESET;
    logic              WICENREQ, WICENACK, WICDSREQn, WICDSACKn;
    logic              WICLOAD, WICCLEAR;
    logic [NUMIRQ-1:0] WICMASKISR, IRQ;
    logic              WICMASKNMI, WICMASKRXEV, NMI, RXEV;
    logic [W-1:0]      WICSENSE, WICPEND;
    logic              WAKEUP;

    int n_chk  = 0;
    int n_fail = 0;

    cm0_wakeup_ctrl #(.NUMIRQ(NUMIRQ)) dut (
        .SCLK(SCLK), .HRESET(HRESET),
        .WICENREQ(WICENREQ), .WICENACK(WICENACK),
        .WICDSREQn(WICDSREQn), .WICDSACKn(WICDSACKn),
        .WICLOAD(WICLOAD), .WICCLEAR(WICCLEAR),
        .WICMASKISR(WICMASKISR), .WICMASKNMI(WICMASKNMI), .WICMASKRXEV(WICMASKRXEV),
        .IRQ(IRQ), .NMI(NMI), .RXEV(RXEV),
        .WICSENSE(WICSENSE), .WICPEND(WICPEND), .WAKEUP(WAKEUP)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = not granted, 1 = asking the core, 2 = granted.
    int           m_mode;
    logic [W-1:0] m_sense, m_pend, m_d1, m_d2;

    always @(posedge SCLK or posedge HRESET) begin : mdl
        logic [W-1:0] seen;
        if (HRESET) begin
            m_mode = 0; m_sense = '0; m_pend = '0; m_d1 = '0; m_d2 = '0;
        end else begin
            seen = {IRQ, NMI, RXEV};
`ifdef WIC_INPUT_SYNC_EN
            seen = m_d2;
            m_d2 = m_d1;
            m_d1 = {IRQ, NMI, RXEV};
`endif
            if (m_mode == 2) begin
                if (WICENREQ && !WICDSACKn) begin
                    m_pend = m_pend | (m_sense & seen);
                    if (WICLOAD) m_sense = {WICMASKISR, WICMASKNMI, WICMASKRXEV};
                end else begin
                    m_pend = '0;
                    m_sense = '0;
                end
            end
            if (WICCLEAR) begin
                m_pend = '0;
                m_sense = '0;
            end
            if (!WICENREQ) m_mode = 0;
            else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && !WICDSACKn) m_mode = 2;
            else if (m_mode == 2 && WICDSACKn) m_mode = 0;
        end
    end

    always @(negedge SCLK) begin
        chk("dsreq_n", 64'(WICDSREQn), 64'(m_mode == 0));
        chk("enack",   64'(WICENACK),  64'(m_mode == 2));
        chk("sense",   64'(WICSENSE),  64'(m_sense));
        chk("pend",    64'(WICPEND),   64'(m_pend));
        chk("wakeup",  64'(WAKEUP),    64'(|m_pend));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge SCLK);
    endtask

    initial begin
        HRESET = 1'b0;
        WICENREQ = 0; WICDSACKn = 1; WICLOAD = 0; WICCLEAR = 0;
        WICMASKISR = '0; WICMASKNMI = 0; WICMASKRXEV = 0;
        IRQ = '0; NMI = 0; RXEV = 0;
        #1 HRESET = 1'b1;
        cyc(2);
        chk("rst_dsreq_n", 64'(WICDSREQn), 64'd1);
        chk("rst_enack", 64'(WICENACK), 64'd0);
        chk("rst_wakeup", 64'(WAKEUP), 64'd0);
        chk("rst_pend", 64'(WICPEND), 64'd0);
        HRESET = 1'b0;

        // Handshake
        WICENREQ = 1;
        cyc(1);
        chk("hs_dsreq_low", 64'(WICDSREQn), 64'd0);
        chk("hs_no_ack_yet", 64'(WICENACK), 64'd0);
        WICDSACKn = 0;
        cyc(1);
        chk("hs_enack", 64'(WICENACK), 64'd1);

        // Load and wake
        WICMASKISR = 32'h0000_0010; WICLOAD = 1;
        cyc(1);
        WICLOAD = 0;
        chk("lw_sense", 64'(WICSENSE), 64'h40);
        IRQ[5] = 1;
        cyc(1);
        IRQ[5] = 0; IRQ[4] = 1;
        chk("lw_irq5_nopend", 64'(WICPEND), 64'h0);
        cyc(LAT);
        chk("lw_pend", 64'(WICPEND), 64'h40);
        chk("lw_wakeup", 64'(WAKEUP), 64'd1);
        IRQ = '0;

        // Clear wins over load
        WICCLEAR = 1; WICLOAD = 1;
        cyc(1);
        WICCLEAR = 0; WICLOAD = 0;
        chk("clr_sense", 64'(WICSENSE), 64'h0);
        chk("clr_pend", 64'(WICPEND), 64'h0);
        chk("clr_wakeup", 64'(WAKEUP), 64'd0);

        // NMI / RXEV
        WICMASKISR = '0; WICMASKNMI = 1; WICMASKRXEV = 0; WICLOAD = 1;
        cyc(1);
        WICLOAD = 0; RXEV = 1;
        cyc(2);
        RXEV = 0; NMI = 1;
        cyc(1);
        NMI = 0;
        cyc(LAT + 1);
        chk("nmi_pend", 64'(WICPEND), 64'h2);
        cyc(2);
        chk("nmi_held", 64'(WICPEND), 64'h2);

        // Exit while armed
        WICMASKISR = 32'h0000_0010; WICMASKNMI = 0; WICCLEAR = 1;
        cyc(1);
        WICCLEAR = 0; WICLOAD = 1;
        cyc(1);
        WICLOAD = 0; IRQ[4] = 1;
        cyc(LAT);
        IRQ = '0;
        chk("exit_armed_pend", 64'(WICPEND), 64'h40);
        WICDSACKn = 1;
        cyc(1);
        chk("exit_pend", 64'(WICPEND), 64'h0);
        chk("exit_sense", 64'(WICSENSE), 64'h0);
        chk("exit_wakeup", 64'(WAKEUP), 64'd0);
        chk("exit_dsreq_n", 64'(WICDSREQn), 64'd1);
        WICLOAD = 1;
        cyc(1);
        WICLOAD = 0;
        chk("off_load_ignored", 64'(WICSENSE), 64'h0);

        // Asynchronous reset while waking
        WICDSACKn = 0;
        cyc(2);
        chk("re_enack", 64'(WICENACK), 64'd1);
        WICLOAD = 1;
        cyc(1);
        WICLOAD = 0; IRQ[4] = 1;
        cyc(LAT);
        IRQ = '0;
        chk("pre_rst_wakeup", 64'(WAKEUP), 64'd1);
        @(posedge SCLK);
        #2 HRESET = 1'b1;
        #1;
        chk("arst_dsreq_n", 64'(WICDSREQn), 64'd1);
        chk("arst_enack", 64'(WICENACK), 64'd0);
        chk("arst_wakeup", 64'(WAKEUP), 64'd0);
        chk("arst_pend", 64'(WICPEND), 64'h0);
        chk("arst_sense", 64'(WICSENSE), 64'h0);
        cyc(1);
        HRESET = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            HRESET      = ($urandom_range(0, 499) == 0);
            WICENREQ    = ($urandom_range(0, 19) != 0);
            WICDSACKn   = ($urandom_range(0, 9) == 0);
            WICLOAD     = ($urandom_range(0, 5) == 0);
            WICCLEAR    = ($urandom_range(0, 24) == 0);
            WICMASKISR  = $urandom;
            WICMASKNMI  = $urandom_range(0, 1);
            WICMASKRXEV = $urandom_range(0, 1);
            IRQ         = $urandom & $urandom & $urandom & $urandom;
            NMI         = ($urandom_range(0, 7) == 0);
            RXEV        = ($urandom_range(0, 7) == 0);
            cyc(1);
        end
        HRESET = 1'b0;
        cyc(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
